// File: rtl/iob_eth_host_ctrl_if.sv
// Register-port bus between the host controller (initiator) and iob_eth (target).
interface iob_eth_host_ctrl_if #(
   parameter int ADDR_W = 12
);
   logic              eth_valid;
   logic              eth_ready;
   logic              eth_wstrb;
   logic [ADDR_W-1:0] eth_addr;
   logic [31:0]       eth_wdata;
   logic [31:0]       eth_rdata;

   modport master (
      output eth_valid, eth_wstrb, eth_addr, eth_wdata,
      input  eth_ready, eth_rdata
   );

   modport slave (
      input  eth_valid, eth_wstrb, eth_addr, eth_wdata,
      output eth_ready, eth_rdata
   );
endinterface

// File: rtl/iob_eth_host_ctrl.sv
// Processor-less host for iob_eth: initialises the core, pushes TX frames from a byte stream
// and drains received frames to a byte stream; stalls freely on tx_valid / rx_ready.
`ifndef ETH_ADDR_W
`define ETH_ADDR_W 12
`endif
`ifndef ETH_STATUS
`define ETH_STATUS 0
`endif
`ifndef ETH_SEND
`define ETH_SEND 1
`endif
`ifndef ETH_RCVACK
`define ETH_RCVACK 2
`endif
`ifndef ETH_TX_NBYTES
`define ETH_TX_NBYTES 4
`endif
`ifndef ETH_RX_NBYTES
`define ETH_RX_NBYTES 5
`endif
`ifndef ETH_SOFTRST
`define ETH_SOFTRST 6
`endif
`ifndef ETH_CRC
`define ETH_CRC 7
`endif

module iob_eth_host_ctrl #(
   parameter int                ADDR_W         = `ETH_ADDR_W,
   parameter logic [ADDR_W-1:0] STATUS_ADDR    = `ETH_STATUS,
   parameter logic [ADDR_W-1:0] SEND_ADDR      = `ETH_SEND,
   parameter logic [ADDR_W-1:0] RCVACK_ADDR    = `ETH_RCVACK,
   parameter logic [ADDR_W-1:0] TX_NBYTES_ADDR = `ETH_TX_NBYTES,
   parameter logic [ADDR_W-1:0] RX_NBYTES_ADDR = `ETH_RX_NBYTES,
   parameter logic [ADDR_W-1:0] SOFTRST_ADDR   = `ETH_SOFTRST,
   parameter logic [ADDR_W-1:0] CRC_ADDR       = `ETH_CRC,
   parameter int                TIMEOUT        = 1024
) (
   input  logic                clk,
   input  logic                rst,
   iob_eth_host_ctrl_if.master eth,
   input  logic                tx_start,
   input  logic [10:0]         tx_len,
   input  logic [7:0]          tx_data,
   input  logic                tx_valid,
   output logic                tx_ready,
   output logic                tx_busy,
   input  logic                rx_en,
   input  logic [10:0]         rx_len,
   output logic [7:0]          rx_data,
   output logic                rx_valid,
   output logic                rx_last,
   input  logic                rx_ready,
   output logic [31:0]         rx_crc,
   output logic                link_up,
   output logic                err
);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [3:0] {
      S_INIT_RST, S_INIT_POLL, S_IDLE, S_TX_DATA, S_TX_NB, S_TX_SEND,
      S_RX_NB, S_RX_CRC, S_RX_DATA, S_RX_OUT, S_RX_ACK
   } state_t;

   state_t            state_q, state_d;
   logic              valid_q, valid_d, pend_q, pend_d, wstrb_q, wstrb_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d, rx_crc_q, rx_crc_d;
   logic [TW-1:0]     tmo_q, tmo_d, poll_q, poll_d;
   logic [10:0]       idx_q, idx_d, tx_len_q, tx_len_d, rx_len_q, rx_len_d;
   logic [7:0]        rx_data_q, rx_data_d;
   logic              busy_q, busy_d, link_q, link_d, err_q, err_d;

   logic              req, req_we, done;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;

   always_comb begin
      state_d   = state_q;
      valid_d   = 1'b0;
      pend_d    = pend_q;
      wstrb_d   = wstrb_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      tmo_d     = tmo_q;
      poll_d    = poll_q;
      idx_d     = idx_q;
      tx_len_d  = tx_len_q;
      rx_len_d  = rx_len_q;
      rx_data_d = rx_data_q;
      rx_crc_d  = rx_crc_q;
      busy_d    = busy_q;
      link_d    = link_q;
      err_d     = err_q;
      req       = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      // ready is only meaningful once the one-cycle valid pulse has gone
      done      = pend_q && !valid_q && eth.eth_ready;

      if (tx_start) begin
         if (busy_q || tx_len == 11'd0) begin
            err_d = 1'b1;
         end else begin
            busy_d   = 1'b1;
            tx_len_d = tx_len;
         end
      end

      case (state_q)
         S_INIT_RST: begin
            req = 1'b1; req_we = 1'b1; req_addr = SOFTRST_ADDR; req_wdata = 32'd1;
            if (done) begin
               state_d = S_INIT_POLL;
               poll_d  = '0;
            end
         end
         S_INIT_POLL: begin
            req = 1'b1; req_addr = STATUS_ADDR;
            if (done) begin
               if (eth.eth_rdata[3] && eth.eth_rdata[15]) begin
                  link_d  = 1'b1;
                  state_d = S_IDLE;
               end else if (poll_q == TW'(TIMEOUT - 1)) begin
                  err_d   = 1'b1;
                  state_d = S_INIT_RST;
               end else begin
                  poll_d = poll_q + 1'b1;
               end
            end
         end
         S_IDLE: begin
            req = 1'b1; req_addr = STATUS_ADDR;
            if (done) begin
               idx_d = '0;
               if (rx_en && eth.eth_rdata[1]) begin
                  rx_len_d = rx_len;
                  state_d  = S_RX_NB;
               end else if (busy_q && eth.eth_rdata[0]) begin
                  state_d = S_TX_DATA;
               end
            end
         end
         S_TX_DATA: begin
            req = tx_valid; req_we = 1'b1;
            req_addr = ADDR_W'({1'b1, idx_q}); req_wdata = {24'd0, tx_data};
            if (done) begin
               if (idx_q == tx_len_q - 11'd1) state_d = S_TX_NB;
               else                          idx_d   = idx_q + 11'd1;
            end
         end
         S_TX_NB: begin
            req = 1'b1; req_we = 1'b1; req_addr = TX_NBYTES_ADDR; req_wdata = {21'd0, tx_len_q};
            if (done) state_d = S_TX_SEND;
         end
         S_TX_SEND: begin
            req = 1'b1; req_we = 1'b1; req_addr = SEND_ADDR; req_wdata = 32'd1;
            if (done) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         S_RX_NB: begin
            req = 1'b1; req_we = 1'b1; req_addr = RX_NBYTES_ADDR; req_wdata = {21'd0, rx_len_q};
            if (done) state_d = S_RX_CRC;
         end
         S_RX_CRC: begin
            req = 1'b1; req_addr = CRC_ADDR;
            if (done) begin
               rx_crc_d = eth.eth_rdata;
               state_d  = (rx_len_q == 11'd0) ? S_RX_ACK : S_RX_DATA;
            end
         end
         S_RX_DATA: begin
            req = 1'b1; req_addr = ADDR_W'({1'b1, idx_q});
            if (done) begin
               rx_data_d = eth.eth_rdata[7:0];
               state_d   = S_RX_OUT;
            end
         end
         S_RX_OUT: begin
            if (rx_ready) begin
               if (idx_q == rx_len_q - 11'd1) begin
                  state_d = S_RX_ACK;
               end else begin
                  idx_d   = idx_q + 11'd1;
                  state_d = S_RX_DATA;
               end
            end
         end
         S_RX_ACK: begin
            req = 1'b1; req_we = 1'b1; req_addr = RCVACK_ADDR; req_wdata = 32'd1;
            if (done) state_d = S_IDLE;
         end
         default: state_d = S_INIT_RST;
      endcase

      if (req && !pend_q) begin
         valid_d = 1'b1;
         pend_d  = 1'b1;
         wstrb_d = req_we;
         addr_d  = req_addr;
         wdata_d = req_wdata;
         tmo_d   = '0;
      end
      if (done) pend_d = 1'b0;

      // a stuck target abandons the access and any frame in flight, then re-inits
      if (pend_q && !valid_q && !eth.eth_ready) begin
         if (tmo_q == TW'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            pend_d  = 1'b0;
            link_d  = 1'b0;
            busy_d  = 1'b0;
            state_d = S_INIT_RST;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_INIT_RST;
         valid_q   <= 1'b0;
         pend_q    <= 1'b0;
         wstrb_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         tmo_q     <= '0;
         poll_q    <= '0;
         idx_q     <= '0;
         tx_len_q  <= '0;
         rx_len_q  <= '0;
         rx_data_q <= '0;
         rx_crc_q  <= '0;
         busy_q    <= 1'b0;
         link_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         valid_q   <= valid_d;
         pend_q    <= pend_d;
         wstrb_q   <= wstrb_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         tmo_q     <= tmo_d;
         poll_q    <= poll_d;
         idx_q     <= idx_d;
         tx_len_q  <= tx_len_d;
         rx_len_q  <= rx_len_d;
         rx_data_q <= rx_data_d;
         rx_crc_q  <= rx_crc_d;
         busy_q    <= busy_d;
         link_q    <= link_d;
         err_q     <= err_d;
      end
   end

   assign eth.eth_valid = valid_q;
   assign eth.eth_wstrb = wstrb_q;
   assign eth.eth_addr  = addr_q;
   assign eth.eth_wdata = wdata_q;
   assign tx_ready      = !rst && state_q == S_TX_DATA && !pend_q && tx_valid;
   assign tx_busy       = busy_q;
   assign rx_data       = rx_data_q;
   assign rx_valid      = state_q == S_RX_OUT;
   assign rx_last       = rx_valid && idx_q == rx_len_q - 11'd1;
   assign rx_crc        = rx_crc_q;
   assign link_up       = link_q;
   assign err           = err_q;
endmodule

// File: tb/tb_iob_eth_host_ctrl.sv
// Bench for iob_eth_host_ctrl: register-file model of iob_eth on the bus, random stream
// source/sink, expected bus traffic derived from the frame-level rules.
module tb_iob_eth_host_ctrl;
   localparam int AW = 12;
   localparam logic [11:0] A_STATUS = 12'h000, A_SEND = 12'h001, A_RCVACK = 12'h002,
                           A_TXNB = 12'h004, A_RXNB = 12'h005, A_SOFTRST = 12'h006,
                           A_CRC = 12'h007;

   typedef struct packed { logic [11:0] a; logic [31:0] d; } wr_t;
   typedef struct {
      logic [1:0] flags;  // STATUS[1:0] presented once the link is up
      bit rx_en; bit tx_req; int tlen; int rlen; bit fixed;
      int exp_first;      // 0 no frame activity, 1 RX first, 2 TX first
      bit exp_busy;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   iob_eth_host_ctrl_if #(.ADDR_W(AW)) bus ();
   logic tx_start = 1'b0, tx_valid, tx_ready, tx_busy, rx_en = 1'b0;
   logic rx_valid, rx_last, rx_ready, link_up, err;
   logic [10:0] tx_len = '0, rx_len = '0;
   logic [7:0]  tx_data, rx_data;
   logic [31:0] rx_crc;

   iob_eth_host_ctrl #(
      .ADDR_W(AW), .STATUS_ADDR(A_STATUS), .SEND_ADDR(A_SEND), .RCVACK_ADDR(A_RCVACK),
      .TX_NBYTES_ADDR(A_TXNB), .RX_NBYTES_ADDR(A_RXNB), .SOFTRST_ADDR(A_SOFTRST),
      .CRC_ADDR(A_CRC), .TIMEOUT(1024)
   ) dut (
      .clk(clk), .rst(rst), .eth(bus),
      .tx_start(tx_start), .tx_len(tx_len), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .tx_busy(tx_busy), .rx_en(rx_en), .rx_len(rx_len),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_last(rx_last), .rx_ready(rx_ready),
      .rx_crc(rx_crc), .link_up(link_up), .err(err)
   );

   int n_tests = 0, n_fail = 0;
   wr_t wlog[$];
   logic [7:0] tx_q[$], rx_got[$];
   bit rx_lastq[$];
   logic [15:0] status_v = 16'h0;
   logic [31:0] crc_v = 32'h0;
   logic [7:0] rx_buf [0:2047];
   int status_reads = 0, zero_polls = 3;
   bit hang = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic int count_addr(input logic [11:0] a);
      int n = 0;
      foreach (wlog[i]) if (wlog[i].a == a) n++;
      return n;
   endfunction

   // iob_eth register model: answers each access 2..4 cycles after the valid pulse
   initial begin
      bit busy_s = 1'b0;
      int cnt = 0;
      logic [31:0] rv = '0;
      bus.eth_ready = 1'b0;
      bus.eth_rdata = '0;
      forever begin
         @(negedge clk);
         bus.eth_ready = 1'b0;
         if (busy_s && !hang) begin
            if (cnt <= 1) begin
               bus.eth_ready = 1'b1;
               bus.eth_rdata = rv;
               busy_s = 1'b0;
            end else cnt--;
         end
         if (rst || hang) busy_s = 1'b0;
         if (bus.eth_valid) begin
            busy_s = 1'b1;
            cnt = $urandom_range(1, 3);
            rv = $urandom;
            if (bus.eth_wstrb) begin
               wlog.push_back({bus.eth_addr, bus.eth_wdata});
               if (bus.eth_addr == A_RCVACK) status_v[1] = 1'b0;
            end else if (bus.eth_addr == A_STATUS) begin
               rv = (status_reads < zero_polls) ? 32'h0 : {16'h0, status_v};
               status_reads++;
            end else if (bus.eth_addr == A_CRC) begin
               rv = crc_v;
            end else if (bus.eth_addr[11]) begin
               rv[7:0] = rx_buf[bus.eth_addr[10:0]];
            end
         end
      end
   end

   // TX byte source with random gaps
   initial begin
      tx_valid = 1'b0;
      tx_data = '0;
      forever begin
         @(negedge clk);
         if (tx_q.size() > 0 && $urandom_range(0, 3) != 0) begin
            tx_valid = 1'b1;
            tx_data = tx_q[0];
         end else tx_valid = 1'b0;
         #1;
         if (tx_valid && tx_ready) void'(tx_q.pop_front());
      end
   end

   // RX sink with toggling ready
   initial begin
      rx_ready = 1'b0;
      forever begin
         @(negedge clk);
         rx_ready = 1'($urandom_range(0, 1));
         if (rx_valid && rx_ready) begin
            rx_got.push_back(rx_data);
            rx_lastq.push_back(rx_last);
         end
      end
   end

   task automatic wait_link(input string name);
      int cyc = 0;
      while (!link_up && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      check(name, link_up, 1);
   endtask

   task automatic do_init();
      rst = 1'b1;
      tx_start = 1'b0;
      rx_en = 1'b0;
      repeat (3) @(negedge clk);
      tx_q.delete();
      check("reset_outputs", {bus.eth_valid, tx_ready, tx_busy, rx_valid, rx_last, link_up,
                              err, rx_data, rx_crc}, 64'd0);
      wlog.delete();
      rx_got.delete();
      rx_lastq.delete();
      status_reads = 0;
      zero_polls = 3;
      status_v = 16'h8008;
      rst = 1'b0;
      wait_link("init_link");
      check("init_status_polls", status_reads, 4);
      check("init_err", err, 0);
   endtask

   task automatic pulse_start(input int n);
      @(negedge clk);
      tx_len = 11'(n);
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
   endtask

   task automatic run_row(input int r, input vec_t v);
      logic [7:0] txb[$];
      wr_t exp[$];
      int tl, rl, cyc, first;
      bit rx_go, tx_go;
      tl = (v.tlen < 0) ? $urandom_range(1, 40) : v.tlen;
      rl = (v.rlen < 0) ? $urandom_range(1, 40) : v.rlen;
      crc_v = v.fixed ? 32'hDEADBEEF : $urandom;
      for (int i = 0; i < rl; i++) rx_buf[i] = v.fixed ? 8'((i + 1) * 17) : 8'($urandom_range(0, 255));
      for (int i = 0; i < tl; i++) txb.push_back(v.fixed ? 8'(161 + i * 17) : 8'($urandom_range(0, 255)));
      do_init();
      if (v.tx_req) begin
         foreach (txb[i]) tx_q.push_back(txb[i]);
         pulse_start(tl);
         check("busy_after_start", tx_busy, 1);
      end
      rx_len = 11'(rl);
      rx_en = v.rx_en;
      status_v = 16'h8008 | 16'(v.flags);

      rx_go = v.rx_en && v.flags[1];
      tx_go = v.tx_req && v.flags[0];
      exp.push_back({A_SOFTRST, 32'd1});
      if (rx_go) begin
         exp.push_back({A_RXNB, 32'(rl)});
         exp.push_back({A_RCVACK, 32'd1});
      end
      if (tx_go) begin
         for (int i = 0; i < tl; i++) exp.push_back({12'(12'h800 + i), 32'(txb[i])});
         exp.push_back({A_TXNB, 32'(tl)});
         exp.push_back({A_SEND, 32'd1});
      end

      cyc = 0;
      while (wlog.size() < exp.size() && cyc < 30000) begin
         @(negedge clk);
         cyc++;
      end
      repeat (40) @(negedge clk);

      check($sformatf("row%0d_wr_count", r), wlog.size(), exp.size());
      for (int i = 0; i < exp.size() && i < wlog.size(); i++)
         check($sformatf("row%0d_wr%0d", r, i), wlog[i], exp[i]);
      first = 0;
      if (wlog.size() > 1)
         first = (wlog[1].a == A_RXNB) ? 1 : ((wlog[1].a[11] || wlog[1].a == A_TXNB) ? 2 : 3);
      check($sformatf("row%0d_first_seq", r), first, v.exp_first);
      check($sformatf("row%0d_rx_count", r), rx_got.size(), rx_go ? rl : 0);
      if (rx_go) begin
         for (int i = 0; i < rl && i < rx_got.size(); i++) begin
            check($sformatf("row%0d_rx_byte%0d", r, i), rx_got[i], rx_buf[i]);
            check($sformatf("row%0d_rx_last%0d", r, i), rx_lastq[i], i == rl - 1);
         end
         check($sformatf("row%0d_rx_crc", r), rx_crc, crc_v);
      end
      check($sformatf("row%0d_tx_busy", r), tx_busy, v.exp_busy);
      check($sformatf("row%0d_err", r), err, 0);
      rx_en = 1'b0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      vec_t vt[9];
      int cyc;
      vt[0] = '{2'b01, 1'b0, 1'b1, 4,    0,  1'b1, 2, 1'b0};
      vt[1] = '{2'b10, 1'b1, 1'b0, 0,    3,  1'b1, 1, 1'b0};
      vt[2] = '{2'b11, 1'b1, 1'b1, -1,   -1, 1'b0, 1, 1'b0};
      vt[3] = '{2'b11, 1'b0, 1'b1, -1,   -1, 1'b0, 2, 1'b0};
      vt[4] = '{2'b10, 1'b0, 1'b1, -1,   -1, 1'b0, 0, 1'b1};
      vt[5] = '{2'b00, 1'b1, 1'b1, -1,   -1, 1'b0, 0, 1'b1};
      vt[6] = '{2'b01, 1'b1, 1'b1, 2047, 3,  1'b0, 2, 1'b0};
      vt[7] = '{2'b10, 1'b1, 1'b0, 0,    1,  1'b0, 1, 1'b0};
      vt[8] = '{2'b11, 1'b1, 1'b1, 1,    5,  1'b0, 1, 1'b0};

      for (int r = 0; r < 9; r++) run_row(r, vt[r]);

      // zero-length start is rejected without touching the bus
      do_init();
      status_v = 16'h8009;
      pulse_start(0);
      repeat (30) @(negedge clk);
      check("len0_err", err, 1);
      check("len0_busy", tx_busy, 0);
      check("len0_writes", wlog.size(), 1);

      // second start while a frame is pending
      do_init();
      pulse_start(3);
      pulse_start(3);
      repeat (5) @(negedge clk);
      check("restart_err", err, 1);
      check("restart_busy", tx_busy, 1);

      // target never answers
      do_init();
      hang = 1'b1;
      cyc = 0;
      while (!err && cyc < 1500) begin
         @(negedge clk);
         cyc++;
      end
      check("tmo_err", err, 1);
      check("tmo_window", (cyc >= 1000 && cyc <= 1040), 1);
      check("tmo_link_down", link_up, 0);
      hang = 1'b0;
      wait_link("tmo_relink");
      check("tmo_softrst_again", count_addr(A_SOFTRST), 2);

      // reset in the middle of a frame
      do_init();
      status_v = 16'h8009;
      for (int i = 0; i < 6; i++) tx_q.push_back(8'(i + 1));
      pulse_start(6);
      cyc = 0;
      while (wlog.size() < 3 && cyc < 500) begin
         @(negedge clk);
         cyc++;
      end
      check("midtx_two_bytes", wlog.size(), 3);
      rst = 1'b1;
      @(negedge clk);
      check("midtx_valid", bus.eth_valid, 0);
      check("midtx_busy", tx_busy, 0);
      rst = 1'b0;
      tx_q.delete();
      wait_link("midtx_relink");
      repeat (20) @(negedge clk);
      check("midtx_no_send", count_addr(A_SEND), 0);
      check("midtx_no_txnb", count_addr(A_TXNB), 0);
      check("midtx_softrst", count_addr(A_SOFTRST), 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/iob_eth_host_ctrl.md
Name: iob_eth_host_ctrl

Overview:
- Hardware host that drives the CPU-side register port of iob_eth as bus initiator, so frames move without a processor.
- Accepts a user byte stream plus length and sends it as a frame; polls for received frames and streams their bytes back out with length and CRC.
- Sits in the system clock domain, directly on the iob_eth valid/ready/wstrb/addr/data_in/data_out port.

Parameters:
- ADDR_W, `ETH_ADDR_W, width of the eth_addr bus.
- STATUS_ADDR, SEND_ADDR, RCVACK_ADDR, TX_NBYTES_ADDR, RX_NBYTES_ADDR, SOFTRST_ADDR, CRC_ADDR: defaults `ETH_STATUS, `ETH_SEND, `ETH_RCVACK, `ETH_TX_NBYTES, `ETH_RX_NBYTES, `ETH_SOFTRST, `ETH_CRC; register addresses.
- TIMEOUT, 1024, cycles allowed for eth_ready, and for PHY-up after init, before an error is raised.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- eth_valid  out  1  access request to iob_eth
- eth_ready  in  1  iob_eth ready
- eth_wstrb  out  1  1 = write
- eth_addr  out  ADDR_W  register or buffer address
- eth_wdata  out  32  write data
- eth_rdata  in  32  read data
- tx_start  in  1  pulse: begin a frame of tx_len bytes
- tx_len  in  11  TX byte count, sampled on tx_start
- tx_data  in  8  TX byte
- tx_valid  in  1  TX byte valid
- tx_ready  out  1  TX byte accepted
- tx_busy  out  1  TX frame in progress
- rx_en  in  1  enable receive polling
- rx_len  in  11  expected RX byte count, sampled at each RX start
- rx_data  out  8  RX byte
- rx_valid  out  1  RX byte valid
- rx_last  out  1  final RX byte
- rx_ready  in  1  sink accepts RX byte
- rx_crc  out  32  CRC of last frame, latched
- link_up  out  1  init complete
- err  out  1  sticky: bus or PHY timeout, or illegal tx_start

Behaviour:
- Reset values: all outputs 0. The reset returns the FSM to INIT and aborts any access, with eth_valid 0 on the next cycle.
- Bus rule:
  - eth_valid is a single-cycle pulse.
  - eth_addr, eth_wstrb and eth_wdata are held from the pulse until eth_ready=1.
  - Read data is sampled on the eth_ready cycle.
  - The next pulse comes no earlier than the cycle after eth_ready.
  - A minimal access takes 2 cycles.
  - eth_ready held low for TIMEOUT cycles sets err and returns the FSM to INIT.
- Buffer address: {1'b1, idx[10:0]}, with data in wdata[7:0] or rdata[7:0].
- STATUS bits: [0] tx_ready, [1] rx_data_rcvd, [2] phy_dv_detected, [3] phy_clk_detected, [15] pll_locked.
- INIT:
  - Write SOFTRST with data 1.
  - Poll STATUS until bit3 and bit15 are both 1, then set link_up=1 and go to IDLE.
  - Exceeding TIMEOUT polls sets err and restarts INIT.
- IDLE:
  - Read STATUS.
  - If rx_en and bit1: go to RX. RX has priority.
  - Else if a TX request is pending and bit0: go to TX.
  - Else re-poll.
- tx_start handling:
  - Latched as pending; tx_busy=1 from the next cycle.
  - tx_start with tx_len=0, or while tx_busy, is ignored and sets err.
- TX sequence:
  - TX_DATA: for idx 0..len-1, assert tx_ready for one cycle when tx_valid, take the byte, write it to buffer idx.
  - TX_NB: write TX_NBYTES = len.
  - TX_SEND: write SEND exactly once.
  - tx_busy drops the cycle after the SEND access completes.
- RX sequence:
  - RX_NB: write RX_NBYTES = rx_len.
  - RX_CRC: read CRC into rx_crc.
  - RX_DATA: for idx 0..rx_len-1, read the buffer byte, then present rx_data/rx_valid until rx_ready. rx_last accompanies idx=rx_len-1.
  - RX_ACK: write RCVACK once, then return to IDLE.
- Backpressure: rx_ready low stalls RX_DATA indefinitely, with no timeout. tx_valid low stalls TX_DATA indefinitely.
- Counters: 11-bit idx. len=2047 is legal. There is no wrap beyond len-1.
- A tx_start arriving during an RX sequence is latched and serviced after RX_ACK.
- rx_en deasserted mid-frame does not abort the frame in progress.

Test Plan:
- Init: release rst, model returns STATUS 0x0000 for 3 polls then 0x8008 -> exactly one SOFTRST write with data 1, then link_up=1, err=0.
- TX: tx_start with tx_len=4, bytes A1 B2 C3 D4 -> buffer writes to 0x800..0x803 with those bytes, then TX_NBYTES=4, then one SEND write; tx_busy low afterwards.
- RX with backpressure:
  - Setup: rx_en=1, rx_len=3, STATUS=0x8003, CRC=0xDEADBEEF, buffer bytes 11 22 33, rx_ready toggling.
  - Expect: RX_NBYTES=3, rx_crc=0xDEADBEEF, bytes 11 22 33 with rx_last on 33, then one RCVACK write.
- Priority: tx_start pending while STATUS=0x8003 and rx_en=1 -> RX sequence completes first, then TX.
- Errors: tx_start with len=0 -> err=1, no bus writes. Model holding eth_ready low for 1024 cycles -> err=1, FSM back in INIT.
- Reset mid-TX after 2 bytes -> eth_valid=0 next cycle, tx_busy=0, no SEND issued, INIT restarts.
